vga_fb_arbiter: RTL and testbench



---
 rtl/vga_fb_arbiter_if.sv | 34 +++
 rtl/vga_fb_arbiter.sv | 170 +++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_arbiter_if.sv
// rtl/vga_fb_arbiter_if.sv - scan-out, CPU write and framebuffer RAM signals of vga_fb_arbiter
interface vga_fb_arbiter_if #(
    parameter int ADDR_W      = 16,
    parameter int RGB_SIZE    = 8,
    parameter int WFIFO_DEPTH = 4
);
    localparam int PIX_W = 3 * RGB_SIZE;
    localparam int LVL_W = $clog2(WFIFO_DEPTH) + 1;

    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [PIX_W-1:0]  vga_rgb;
    logic              vga_valid;
    logic              cpu_wr_valid;
    logic [ADDR_W-1:0] cpu_wr_addr;
    logic [PIX_W-1:0]  cpu_wr_data;
    logic              cpu_wr_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_wdata;
    logic [PIX_W-1:0]  mem_rdata;
    logic [LVL_W-1:0]  wfifo_level;

    modport slave (
        input  vga_req, vga_addr, cpu_wr_valid, cpu_wr_addr, cpu_wr_data, mem_rdata,
        output vga_rgb, vga_valid, cpu_wr_ready, mem_en, mem_we, mem_addr, mem_wdata, wfifo_level
    );

    modport master (
        output vga_req, vga_addr, cpu_wr_valid, cpu_wr_addr, cpu_wr_data, mem_rdata,
        input  vga_rgb, vga_valid, cpu_wr_ready, mem_en, mem_we, mem_addr, mem_wdata, wfifo_level
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - framebuffer RAM arbiter: priority scan-out reads, FIFO-buffered CPU writes
// Optional colour-bar test pattern enabled by VGA_FB_TESTPATTERN_EN.
module vga_fb_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int RGB_SIZE    = 8,
    parameter int WFIFO_DEPTH = 4
) (
    input logic clk,
    input logic reset,
`ifdef VGA_FB_TESTPATTERN_EN
    input logic test_mode,
`endif
    vga_fb_arbiter_if.slave bus
);
    localparam int PIX_W = 3 * RGB_SIZE;
    localparam int PTR_W = $clog2(WFIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, SCAN, TURN, WRITE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
    logic [PIX_W-1:0]  fifo_data [WFIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [LVL_W-1:0]  level_next;
    logic              ready_q;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              rd_issue;
    logic              wr_issue;
    logic              tp_active;
    logic              req_q1;
    logic [PIX_W-1:0]  rd_src;

`ifdef VGA_FB_TESTPATTERN_EN
    logic [2:0]       bar;
    logic             tp_q1;
    logic [PIX_W-1:0] bar_pix_q1;

    assign tp_active = test_mode;
    assign bar       = bus.vga_addr[ADDR_W-1 -: 3];

    // Bar colour follows the same two-stage pipeline as a real RAM read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tp_q1      <= 1'b0;
            bar_pix_q1 <= '0;
        end else begin
            tp_q1      <= test_mode;
            bar_pix_q1 <= {{RGB_SIZE{bar[2]}}, {RGB_SIZE{bar[1]}}, {RGB_SIZE{bar[0]}}};
        end
    end

    assign rd_src = tp_q1 ? bar_pix_q1 : bus.mem_rdata;
`else
    assign tp_active = 1'b0;
    assign rd_src    = bus.mem_rdata;
`endif

    always_comb begin
        fifo_empty = (level == '0);
        push       = bus.cpu_wr_valid && ready_q;
        rd_issue   = bus.vga_req && !tp_active;
        if (tp_active)
            wr_issue = !fifo_empty;
        else
            wr_issue = (state == WRITE) && !bus.vga_req && !fifo_empty;
        pop        = wr_issue;
        level_next = level + LVL_W'(push) - LVL_W'(pop);

        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (rd_issue) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.vga_addr;
        end else if (wr_issue) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = fifo_addr[rd_ptr];
            bus.mem_wdata = fifo_data[rd_ptr];
        end
    end

    // Entry storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.cpu_wr_addr;
            fifo_data[wr_ptr] <= bus.cpu_wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            ready_q <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            level   <= level_next;
            ready_q <= (level_next < LVL_W'(WFIFO_DEPTH));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    // Looking at the push as well lets a lone write retire the very next cycle.
                    if (bus.vga_req)
                        state <= SCAN;
                    else if (!fifo_empty || push)
                        state <= WRITE;
                end
                SCAN: begin
                    if (!bus.vga_req) begin
                        if (!tp_active)
                            state <= TURN;
                        else if (level_next != '0)
                            state <= WRITE;
                        else
                            state <= IDLE;
                    end
                end
                TURN: begin
                    if (bus.vga_req)
                        state <= SCAN;
                    else if (!fifo_empty)
                        state <= WRITE;
                    else
                        state <= IDLE;
                end
                WRITE: begin
                    if (bus.vga_req)
                        state <= SCAN;
                    else if (level_next == '0)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q1        <= 1'b0;
            bus.vga_valid <= 1'b0;
            bus.vga_rgb   <= '0;
        end else begin
            req_q1        <= bus.vga_req;
            bus.vga_valid <= req_q1;
            if (req_q1)
                bus.vga_rgb <= rd_src;
        end
    end

    assign bus.cpu_wr_ready = ready_q;
    assign bus.wfifo_level  = level;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - scoreboard testbench for vga_fb_arbiter with a behavioural framebuffer RAM
module tb_vga_fb_arbiter;
    localparam int ADDR_W = 16;
    localparam int RGB_SIZE = 8;
    localparam int DEPTH = 4;
    localparam int PIX_W = 3 * RGB_SIZE;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic test_mode = 1'b0;

    vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .RGB_SIZE(RGB_SIZE), .WFIFO_DEPTH(DEPTH)) bus();

    vga_fb_arbiter #(.ADDR_W(ADDR_W), .RGB_SIZE(RGB_SIZE), .WFIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
`ifdef VGA_FB_TESTPATTERN_EN
        .test_mode(test_mode),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
    } wr_t;

    typedef struct {
        int               due;
        logic [PIX_W-1:0] data;
    } rd_t;

    int  vectors = 0;
    int  miscompares = 0;
    int  cyc = 0;
    int  wr_seen = 0;
    wr_t wq[$];
    rd_t rq[$];
    logic [PIX_W-1:0] ram [0:(1<<ADDR_W)-1];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we)
                ram[bus.mem_addr] <= bus.mem_wdata;
            else
                bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    always @(negedge clk) begin : monitor
        wr_t we;
        rd_t re;
        if (!reset && bus.mem_en && bus.mem_we) begin
            wr_seen++;
            vectors++;
            if (wq.size() == 0) begin
                miscompares++;
                $display("FAIL write_unexpected: got addr=%h data=%h, required no write", bus.mem_addr, bus.mem_wdata);
            end else begin
                we = wq.pop_front();
                if ({bus.mem_addr, bus.mem_wdata} !== {we.addr, we.data}) begin
                    miscompares++;
                    $display("FAIL write_order: got addr=%h data=%h, required addr=%h data=%h",
                             bus.mem_addr, bus.mem_wdata, we.addr, we.data);
                end
            end
        end
        if (!reset && bus.vga_valid) begin
            vectors++;
            if (rq.size() == 0) begin
                miscompares++;
                $display("FAIL read_unexpected: got vga_valid rgb=%h at cycle %0d, required none", bus.vga_rgb, cyc);
            end else begin
                re = rq.pop_front();
                if (bus.vga_rgb !== re.data || cyc != re.due) begin
                    miscompares++;
                    $display("FAIL read_data: got rgb=%h cycle=%0d, required rgb=%h cycle=%0d",
                             bus.vga_rgb, cyc, re.data, re.due);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (wq.size() == 0 && rq.size() == 0 && bus.wfifo_level == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin
                miscompares++;
                $display("FAIL reset_mem_idle: got en=%b we=%b addr=%h wdata=%h, required all 0",
                         bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
            end
        end
        vectors++;
        if (bus.cpu_wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b, required 1", bus.cpu_wr_ready);
        end
        vectors++;
        if (bus.vga_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b, required 0", bus.vga_valid);
        end
        vectors++;
        if (bus.wfifo_level !== 0) begin
            miscompares++;
            $display("FAIL reset_level: got %0d, required 0", bus.wfifo_level);
        end
        tick();
    endtask

    task automatic test_read_latency;
        bit ok;
        bus.cpu_wr_valid = 1'b1;
        bus.cpu_wr_addr  = 16'h0010;
        bus.cpu_wr_data  = 24'hFF0000;
        wq.push_back('{16'h0010, 24'hFF0000});
        tick();
        bus.cpu_wr_valid = 1'b0;
        wait_drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL preload_drain: got timeout, required drained FIFO");
        end
        tick();
        bus.vga_req  = 1'b1;
        bus.vga_addr = 16'h0010;
        rq.push_back('{cyc + 2, 24'hFF0000});
        @(negedge clk);
        vectors++;
        if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 16'h0010}) begin
            miscompares++;
            $display("FAIL read_issue: got en=%b we=%b addr=%h, required en=1 we=0 addr=0010",
                     bus.mem_en, bus.mem_we, bus.mem_addr);
        end
        tick();
        bus.vga_req = 1'b0;
        wait_drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL read_drain: got timeout, required read returned");
        end
    endtask

    task automatic test_fifo_full_burst;
        bit  ok;
        int  accepted = 0;
        wr_t ent[5];
        for (int i = 0; i < 5; i++) ent[i] = '{16'h0200 + 16'(i), 24'h123400 + 24'(i)};
        bus.vga_req  = 1'b1;
        bus.vga_addr = 16'h0010;
        for (int c = 0; c < 20; c++) begin
            rq.push_back('{cyc + 2, 24'hFF0000});
            bus.cpu_wr_valid = 1'b1;
            bus.cpu_wr_addr  = ent[accepted].addr;
            bus.cpu_wr_data  = ent[accepted].data;
            if (c == 4) begin
                vectors++;
                if (bus.cpu_wr_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL full_ready: got %b, required 0 after 4 pushes", bus.cpu_wr_ready);
                end
            end
            if (bus.cpu_wr_ready) begin
                wq.push_back(ent[accepted]);
                accepted++;
            end
            @(negedge clk);
            vectors++;
            if (bus.mem_we !== 1'b0) begin
                miscompares++;
                $display("FAIL burst_no_write: got mem_we=%b in cycle %0d, required 0", bus.mem_we, c);
            end
            tick();
        end
        bus.vga_req = 1'b0;
        vectors++;
        if (accepted != 4) begin
            miscompares++;
            $display("FAIL burst_accepted: got %0d, required 4", accepted);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++;
            if (bus.mem_en !== 1'b0) begin
                miscompares++;
                $display("FAIL turnaround_idle: got mem_en=%b at step %0d, required 0", bus.mem_en, k);
            end
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            if (accepted == 5) bus.cpu_wr_valid = 1'b0;
            if (bus.cpu_wr_valid && bus.cpu_wr_ready) begin
                wq.push_back(ent[4]);
                accepted++;
            end
            @(negedge clk);
            vectors++;
            if (bus.mem_we !== 1'b1) begin
                miscompares++;
                $display("FAIL drain_consecutive: got mem_we=%b at write %0d, required 1", bus.mem_we, k);
            end
            tick();
        end
        bus.cpu_wr_valid = 1'b0;
        wait_drain(ok);
        vectors++;
        if (!ok || accepted != 5) begin
            miscompares++;
            $display("FAIL burst_drain: got ok=%b accepted=%0d, required ok=1 accepted=5", ok, accepted);
        end
    endtask

    task automatic test_write_preempt;
        bit ok;
        int seen0;
        seen0 = wr_seen;
        bus.vga_req  = 1'b1;
        bus.vga_addr = 16'h0010;
        for (int c = 0; c < 4; c++) begin
            rq.push_back('{cyc + 2, 24'hFF0000});
            if (c < 3) begin
                bus.cpu_wr_valid = 1'b1;
                bus.cpu_wr_addr  = 16'h0300 + 16'(c);
                bus.cpu_wr_data  = 24'hC0DE00 + 24'(c);
                wq.push_back('{16'h0300 + 16'(c), 24'hC0DE00 + 24'(c)});
            end else begin
                bus.cpu_wr_valid = 1'b0;
            end
            tick();
        end
        bus.vga_req = 1'b0;
        tick();
        tick();
        @(negedge clk);
        vectors++;
        if (bus.mem_we !== 1'b1) begin
            miscompares++;
            $display("FAIL preempt_first_write: got mem_we=%b, required 1", bus.mem_we);
        end
        tick();
        bus.vga_req = 1'b1;
        rq.push_back('{cyc + 2, 24'hFF0000});
        @(negedge clk);
        vectors++;
        if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.wfifo_level} !== {1'b1, 1'b0, 16'h0010, 3'd2}) begin
            miscompares++;
            $display("FAIL preempt_read: got en=%b we=%b addr=%h level=%0d, required en=1 we=0 addr=0010 level=2",
                     bus.mem_en, bus.mem_we, bus.mem_addr, bus.wfifo_level);
        end
        tick();
        bus.vga_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++;
            if (bus.mem_en !== 1'b0) begin
                miscompares++;
                $display("FAIL preempt_turn: got mem_en=%b at step %0d, required 0", bus.mem_en, k);
            end
            tick();
        end
        wait_drain(ok);
        vectors++;
        if (!ok || (wr_seen - seen0) != 3) begin
            miscompares++;
            $display("FAIL preempt_retire: got ok=%b writes=%0d, required ok=1 writes=3", ok, wr_seen - seen0);
        end
    endtask

    task automatic test_same_addr;
        bit ok;
        bus.cpu_wr_valid = 1'b1;
        bus.cpu_wr_addr  = 16'h0020;
        bus.cpu_wr_data  = 24'h00FF00;
        wq.push_back('{16'h0020, 24'h00FF00});
        tick();
        bus.cpu_wr_data = 24'h0000FF;
        wq.push_back('{16'h0020, 24'h0000FF});
        @(negedge clk);
        vectors++;
        if ({bus.mem_we, bus.mem_wdata} !== {1'b1, 24'h00FF00}) begin
            miscompares++;
            $display("FAIL earliest_write: got we=%b wdata=%h, required we=1 wdata=00ff00", bus.mem_we, bus.mem_wdata);
        end
        tick();
        bus.cpu_wr_valid = 1'b0;
        wait_drain(ok);
        bus.vga_req  = 1'b1;
        bus.vga_addr = 16'h0020;
        rq.push_back('{cyc + 2, 24'h0000FF});
        tick();
        bus.vga_req = 1'b0;
        wait_drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL same_addr_drain: got timeout, required completion");
        end
    endtask

    task automatic test_reset_midop;
        bit bad_we = 1'b0;
        bit bad_valid = 1'b0;
        bus.vga_req  = 1'b1;
        bus.vga_addr = 16'h0010;
        for (int c = 0; c < 5; c++) begin
            rq.push_back('{cyc + 2, 24'hFF0000});
            if (c < 3) begin
                bus.cpu_wr_valid = 1'b1;
                bus.cpu_wr_addr  = 16'h0400 + 16'(c);
                bus.cpu_wr_data  = 24'hBAD000 + 24'(c);
                wq.push_back('{16'h0400 + 16'(c), 24'hBAD000 + 24'(c)});
            end else begin
                bus.cpu_wr_valid = 1'b0;
            end
            tick();
        end
        vectors++;
        if (bus.wfifo_level !== 3) begin
            miscompares++;
            $display("FAIL midop_level_before: got %0d, required 3", bus.wfifo_level);
        end
        #1 reset = 1'b1;
        wq.delete();
        rq.delete();
        bus.vga_req = 1'b0;
        bus.cpu_wr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.mem_we !== 1'b0) bad_we = 1'b1;
            if (bus.vga_valid !== 1'b0) bad_valid = 1'b1;
        end
        vectors++;
        if (bus.wfifo_level !== 0) begin
            miscompares++;
            $display("FAIL midop_level_after: got %0d, required 0", bus.wfifo_level);
        end
        vectors++;
        if (bad_we || bad_valid) begin
            miscompares++;
            $display("FAIL midop_quiet: got we_seen=%b valid_seen=%b, required 0 0", bad_we, bad_valid);
        end
        tick();
    endtask

    initial begin
        bus.vga_req      = 1'b0;
        bus.vga_addr     = '0;
        bus.cpu_wr_valid = 1'b0;
        bus.cpu_wr_addr  = '0;
        bus.cpu_wr_data  = '0;
        test_reset();
        test_read_latency();
        test_fifo_full_burst();
        test_write_preempt();
        test_same_addr();
        test_reset_midop();
        vectors++;
        if (wq.size() != 0 || rq.size() != 0) begin
            miscompares++;
            $display("FAIL final_queues: got writes=%0d reads=%0d outstanding, required 0 0", wq.size(), rq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
